// File: rtl/pc_ctrl.sv
// Fetch-address unit: PC register, next-PC selection (seq/j/branch/jr, exception, eret),
// fetch-address error detection and saturating branch-statistic counters.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE    = 32'h0000_3000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       d_npc_op,
  input  logic [2:0]       d_branch_op,
  input  logic [31:0]      d_pc,
  input  logic [25:0]      d_instr_index,
  input  logic [15:0]      d_offset,
  input  logic [31:0]      d_rs,
  input  logic [31:0]      d_rt,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  input  logic             cnt_clr,
  output logic [31:0]      f_pc,
  output logic             f_adel,
  output logic             d_taken,
  output logic [31:0]      d_link,
  output logic             flush_fd,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_J   = 2'b01,
    NPC_BR  = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b010,
    BR_GT  = 3'b011,
    BR_LE  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTZ = 3'b110,
    BR_GEZ = 3'b111
  } br_op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      f_pc_q, pc_d;
  logic [CNT_W-1:0] taken_q, taken_d, ntaken_q, ntaken_d;
  logic             cond;
  logic             cnt_inc;
  logic [31:0]      jtarget, btarget;
  logic [32:0]      pc_ext, win_lo, win_hi;
  logic signed [31:0] rs_s, rt_s;

  assign rs_s = d_rs;
  assign rt_s = d_rt;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cond = 1'b0;
    unique case (br_op_e'(d_branch_op))
      BR_EQ:  cond = (rs_s == rt_s);
      BR_NE:  cond = (rs_s != rt_s);
      BR_LT:  cond = (rs_s <  rt_s);
      BR_GT:  cond = (rs_s >  rt_s);
      BR_LE:  cond = (rs_s <= rt_s);
      BR_GE:  cond = (rs_s >= rt_s);
      BR_LTZ: cond = (rs_s <  0);
      BR_GEZ: cond = (rs_s >= 0);
    endcase
  end

  assign d_taken  = (d_npc_op == NPC_BR) && cond;
  assign d_link   = d_pc + 32'd8;
  assign flush_fd = exc_req | eret_req;
  assign jtarget  = {d_pc[31:28], d_instr_index, 2'b00};
  assign btarget  = d_pc + 32'd4 + {{14{d_offset[15]}}, d_offset, 2'b00};

  // Redirects from M outrank the F-stage stall; exception beats eret.
  always_comb begin
    pc_d = f_pc_q + 32'd4;
    if (exc_req)       pc_d = EXC_VECTOR;
    else if (eret_req) pc_d = epc;
    else if (stall)    pc_d = f_pc_q;
    else begin
      unique case (npc_op_e'(d_npc_op))
        NPC_J:   pc_d = jtarget;
        NPC_JR:  pc_d = d_rs;
        NPC_BR:  if (cond) pc_d = btarget;
        NPC_SEQ: pc_d = f_pc_q + 32'd4;
      endcase
    end
  end

  assign cnt_inc = (d_npc_op == NPC_BR) && !stall && !flush_fd;

  always_comb begin
    taken_d  = taken_q;
    ntaken_d = ntaken_q;
    if (cnt_clr) begin
      taken_d  = '0;
      ntaken_d = '0;
    end else if (cnt_inc) begin
      if (d_taken) begin
        if (taken_q != CNT_MAX) taken_d = taken_q + 1'b1;
      end else begin
        if (ntaken_q != CNT_MAX) ntaken_d = ntaken_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q   <= RESET_PC;
      taken_q  <= '0;
      ntaken_q <= '0;
    end else begin
      f_pc_q   <= pc_d;
      taken_q  <= taken_d;
      ntaken_q <= ntaken_d;
    end
  end

  // Window check is done in 33 bits so IM_BASE+IM_SIZE cannot wrap.
  assign pc_ext = {1'b0, f_pc_q};
  assign win_lo = {1'b0, IM_BASE};
  assign win_hi = {1'b0, IM_BASE} + {1'b0, IM_SIZE};
  assign f_adel = (f_pc_q[1:0] != 2'b00) || (pc_ext < win_lo) || (pc_ext >= win_hi);

  assign f_pc       = f_pc_q;
  assign taken_cnt  = taken_q;
  assign ntaken_cnt = ntaken_q;

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised fetch-address unit for the pipelined MIPS core. It combines the architectural PC register with next-PC selection for sequential fetch, j/jal, a generalised conditional branch resolved in D, and jr/jalr. It also handles exception entry and eret redirects arriving from M, fetch-address error detection, and saturating branch-statistic counters. It sits at the F stage, driving the instruction-memory address and taking control from the D-stage decoder and the M-stage CP0.

## Interface
- RESET_PC, 32'h0000_3000, value loaded into the PC on reset.
- EXC_VECTOR, 32'h0000_4180, exception-handler entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_SIZE, 32'h0000_3000, legal fetch window in bytes: [IM_BASE, IM_BASE+IM_SIZE).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold F; the PC keeps its value.
- d_npc_op  in  2  00 sequential, 01 j/jal, 10 conditional branch, 11 jr/jalr.
- d_branch_op  in  3  000 beq, 001 bne, 010 rs<rt, 011 rs>rt, 100 rs<=rt, 101 rs>=rt, 110 rs<0, 111 rs>=0. All comparisons are signed.
- d_pc  in  32  PC of the instruction in D.
- d_instr_index  in  26  j-type index field.
- d_offset  in  16  branch offset field.
- d_rs, d_rt  in  32  forwarded register values.
- exc_req  in  1  exception taken in M.
- eret_req  in  1  eret committing in M.
- epc  in  32  return address for eret.
- cnt_clr  in  1  clear both statistics counters.
- f_pc  out  32  current fetch address.
- f_adel  out  1  fetch address is misaligned or outside the window.
- d_taken  out  1  the D-stage branch condition holds.
- d_link  out  32  link address, d_pc+8.
- flush_fd  out  1  kill the F/D contents (exception or eret).
- taken_cnt, ntaken_cnt  out  CNT_W  saturating counts of taken and not-taken branches.

## Operation
- Condition: d_taken = selected comparison of d_rs against d_rt, or of d_rs against 0 for codes 110 and 111.
  - d_taken is 0 whenever d_npc_op != 10.
- Target computation, delay-slot semantics:
  - seq = f_pc+4.
  - jtarget = {d_pc[31:28], d_instr_index, 2'b00}.
  - btarget = d_pc+4+(sign-extended offset<<2).
  - rtarget = d_rs.
- next_pc priority, highest first:
  1. reset → RESET_PC.
  2. exc_req → EXC_VECTOR.
  3. eret_req → epc.
  4. stall → f_pc (hold).
  5. d_npc_op 01 → jtarget; 11 → rtarget; 10 with d_taken → btarget.
  6. Otherwise seq.
- exc_req together with eret_req: exc_req wins.
- exc_req or eret_req overrides stall.
- flush_fd = exc_req | eret_req. It is combinational and covers the same cycle.
- f_adel = f_pc[1:0]!=0, or f_pc<IM_BASE, or f_pc>=IM_BASE+IM_SIZE.
  - Compare as 33-bit unsigned so IM_BASE+IM_SIZE cannot wrap.
  - f_pc is still emitted unchanged when f_adel is set; M raises the exception.
- All adds wrap modulo 2^32. A jr to a misaligned address is loaded as-is and flagged through f_adel.
- Counters:
  - Each counter increments once per cycle in which d_npc_op==10 and !stall and !flush_fd.
  - taken_cnt increments if d_taken, otherwise ntaken_cnt.
  - Both saturate at 2^CNT_W−1.
  - Priority: reset > cnt_clr > increment. cnt_clr in the same cycle as an increment leaves the counter at 0.

## Timing
- Reset values:
  - f_pc=RESET_PC.
  - taken_cnt=ntaken_cnt=0.
  - f_adel reflects RESET_PC, which is 0 with the default parameters.
  - flush_fd and d_taken are combinational from their inputs.
- Latency:
  - A redirect decided in cycle n appears on f_pc in cycle n+1.
  - The delay-slot instruction is the one fetched in cycle n; it is not flushed by branches or jumps.
- d_taken and d_link are combinational in the same cycle as the D inputs.
- Reset asserted mid-redirect: RESET_PC wins and the counters clear.
- Stall held for k cycles: f_pc is constant for k cycles and the counters do not change.

## Test plan
- Reset with all other inputs 0 → f_pc=0x3000, counters 0. Four free cycles → f_pc=0x3010.
- Branch: d_pc=0x3004, d_npc_op=10, d_branch_op=010, d_rs=−1, d_rt=1, offset=0xFFFF → d_taken=1, next f_pc=0x3004, taken_cnt=1. The same with d_rs=2 → seq and ntaken_cnt=1.
- j: d_pc=0x3008, d_npc_op=01, index=0x0000C10 → next f_pc=0x3040. jr with d_rs=0x3002 → f_pc=0x3002 and f_adel=1.
- stall=1 with a branch active for 3 cycles → f_pc held and counters unchanged.
- stall, exc_req and eret_req all set (epc=0x3100) in one cycle → flush_fd=1 and next f_pc=0x4180. eret_req alone next → f_pc=0x3100.
- CNT_W=2: five taken branches → taken_cnt=3. cnt_clr together with a taken branch → taken_cnt=0.
